ecc_mem_bridge: RTL and testbench
=================================

ECC_MEM_BRIDGE -- requirements
Module: ecc_mem_bridge

Interface
REQ-001 SHALL have parameter DATA_W, default 16: MCU data word width in bits.
REQ-002 SHALL have parameter N_BANKS, default 2: number of memory banks, each written with an identical encoded word, range 1..4.
REQ-003 SHALL have parameter WR_CYCLES, default 2: number of cycles the memory bus is driven per write, minimum 1.
REQ-004 SHALL have parameter RD_LAT, default 2: number of cycles from read start to memory sample, minimum 1.
REQ-005 SHALL have parameter CNT_W, default 8: width of each error counter.
REQ-006 clk  in  1  single clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 mcu_fpga_io  inout  DATA_W  bidirectional MCU data bus.
REQ-009 fpga_mem_io  inout  N_BANKS*DATA_W  bank b occupies bits [b*DATA_W +: DATA_W].
REQ-010 write_en  in  1  active-low write strobe.
REQ-011 output_en  in  1  active-low read strobe.
REQ-012 chip_sel  in  2  selected when either bit is 0; deselected only when both bits are 1.
REQ-013 ecc_sel  in  3  codec mode, passed unchanged to every bank codec.
REQ-014 flag_out  out  3  registered read status: [0] single error corrected; [1] uncorrectable error; [2] banks disagree.
REQ-015 busy  out  1  high while a transaction is in progress.
REQ-016 corr_cnt, uncorr_cnt  out  CNT_W each  saturating event counters.

Function
REQ-017 SHALL implement FSM IDLE, WRITE, READ_WAIT, READ_DONE.
REQ-018 IDLE: in a cycle where the block is selected and write_en is 0, it SHALL capture mcu_fpga_io into a write register and go to WRITE; write SHALL take priority over a simultaneous output_en=0.
REQ-019 IDLE: when selected with output_en=0 and write_en=1, it SHALL go to READ_WAIT.
REQ-020 WRITE: it SHALL drive the encoded write register onto every bank for exactly WR_CYCLES cycles, then return to IDLE; flag_out SHALL be 3'b000 from the first WRITE cycle.
REQ-021 READ_WAIT: after RD_LAT cycles it SHALL sample all banks into decode registers and go to READ_DONE.
REQ-022 READ_DONE: it SHALL register the decoded data and flag_out one cycle after the sample, update the counters, then go to IDLE.
REQ-023 Bank selection: it SHALL return the data of the lowest-index bank with no uncorrectable error; if every bank is uncorrectable, it SHALL return bank 0 data and set flag[1].
REQ-024 flag[2] SHALL be set when the decoded words of the banks are not all equal; it SHALL always be 0 when N_BANKS=1.
REQ-025 mcu_fpga_io SHALL be driven with the read data register only while the state is IDLE, the block is selected, output_en=0, write_en=1, and a read has completed since the last write or reset; otherwise it SHALL be high-Z.
REQ-026 fpga_mem_io SHALL be driven only in WRITE and SHALL be high-Z in all other states; MCU and memory drive SHALL never overlap in the same cycle.
REQ-027 flag_out SHALL hold its value in every cycle that does not update it.
REQ-028 The counters SHALL increment once per read, by flag[0] and flag[1] respectively, and SHALL saturate at all-ones without wrapping.
REQ-029 A strobe held low across the return to IDLE SHALL start a new transaction in the following cycle.
REQ-030 Deselection in the middle of a transaction SHALL NOT abort it.
REQ-031 busy SHALL be 1 in every state except IDLE.

Reset
REQ-032 While rst_n=0: state IDLE, flag_out=0, busy=0, both counters=0, data and write registers=0, the read-valid marker cleared, both buses high-Z.
REQ-033 Reset assertion during WRITE or READ_WAIT SHALL release both buses asynchronously, with no partial update of the counters.
REQ-034 Deassertion SHALL take effect on the first rising clk edge after rst_n goes high.

Structure
REQ-035 Flag bit indices, FSM state enum and the bank-mismatch encoding SHALL be defined in shared package ecc_mem_pkg.
REQ-036 The block SHALL contain N_BANKS instances of the sub-module ecc_bank_codec, each providing a combinational encode, decode and 2-bit status (corrected, uncorrectable) per bank.

Verification
REQ-037 Write 16'hA5A5 with chip_sel=2'b10, WR_CYCLES=2 -> fpga_mem_io driven for exactly 2 cycles, identical in both banks, flag_out=0, busy high for 2 cycles.
REQ-038 Read a clean word after that write -> mcu_fpga_io=16'hA5A5 RD_LAT+2 cycles after output_en falls, flag_out=3'b000, counters unchanged.
REQ-039 Inject a single-bit flip in bank 0 -> data 16'hA5A5, flag_out=3'b001, corr_cnt +1.
REQ-040 Double-bit error in bank 0 with bank 1 clean -> bank 1 data returned, flag_out=3'b110, uncorr_cnt +1.
REQ-041 write_en and output_en fall in the same cycle -> write performed, no read; 300 corrected reads with CNT_W=8 -> corr_cnt stops at 8'hFF.
REQ-042 rst_n pulsed low during WRITE cycle 1 -> buses high-Z immediately, all outputs zero, next read returns no drive until a read completes.

Source files
------------

// File: rtl/ecc_mem_pkg.sv
// Shared types and helpers for the ECC memory bridge: FSM states, flag bit positions,
// bank agreement encoding and the SECDED (Hamming plus overall parity) geometry.
package ecc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_READ_DONE
    } bridge_state_e;

    localparam int FLAG_CORR     = 0;
    localparam int FLAG_UNCORR   = 1;
    localparam int FLAG_MISMATCH = 2;

    localparam int STAT_CORR   = 0;
    localparam int STAT_UNCORR = 1;

    typedef enum logic {
        BANKS_AGREE  = 1'b0,
        BANKS_DIFFER = 1'b1
    } bank_match_e;

    // Any other ecc_sel value selects full SECDED correction.
    localparam logic [2:0] ECC_BYPASS = 3'b111;

    function automatic int ecc_parity_bits(input int data_w);
        int p = 1;
        while ((1 << p) < data_w + p + 1) p = p + 1;
        return p;
    endfunction

    // Codeword position (1-based) of data bit idx; powers of two hold check bits.
    function automatic int ecc_data_pos(input int idx);
        int pos  = 2;
        int seen = -1;
        while (seen < idx) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) != 0) seen = seen + 1;
        end
        return pos;
    endfunction

endpackage

// File: rtl/ecc_bank_codec.sv
// Per-bank SECDED codec: the data word travels to memory unchanged while its check
// bits stay in the bridge, and decode corrects single and flags double errors.
module ecc_bank_codec
    import ecc_mem_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int P      = ecc_parity_bits(DATA_W),
    localparam int CHK_W  = P + 1
) (
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] rd_word,
    input  logic [CHK_W-1:0]  rd_chk,
    output logic [DATA_W-1:0] enc_word,
    output logic [CHK_W-1:0]  enc_chk,
    output logic [DATA_W-1:0] dec_data,
    output logic [1:0]        status
);

    logic [P-1:0] pos [DATA_W];
    logic [P-1:0] hamming;
    logic [P-1:0] syndrome;
    logic         overall;

    for (genvar i = 0; i < DATA_W; i++) begin : g_pos
        assign pos[i] = P'(ecc_data_pos(i));
    end

    assign enc_word = wr_data;

    always_comb begin
        hamming = '0;
        for (int j = 0; j < P; j++) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (pos[i][j]) hamming[j] = hamming[j] ^ wr_data[i];
            end
        end
        enc_chk = {^{wr_data, hamming}, hamming};
    end

    // Odd overall parity means one flipped bit, located by the syndrome; even parity
    // with a non-zero syndrome means two flips, which cannot be repaired.
    always_comb begin
        syndrome = rd_chk[P-1:0];
        for (int j = 0; j < P; j++) begin
            for (int i = 0; i < DATA_W; i++) begin
                if (pos[i][j]) syndrome[j] = syndrome[j] ^ rd_word[i];
            end
        end
        overall  = ^{rd_word, rd_chk};
        dec_data = rd_word;
        status   = '0;
        if (mode != ECC_BYPASS) begin
            if (overall) begin
                status[STAT_CORR] = 1'b1;
                for (int i = 0; i < DATA_W; i++) begin
                    if (pos[i] == syndrome) dec_data[i] = ~rd_word[i];
                end
            end else if (syndrome != '0) begin
                status[STAT_UNCORR] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ecc_mem_bridge.sv
// MCU-to-memory bridge that mirrors each write into N_BANKS protected banks and on
// read returns the first recoverable bank together with error and agreement flags.
module ecc_mem_bridge
    import ecc_mem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int N_BANKS   = 2,
    parameter int WR_CYCLES = 2,
    parameter int RD_LAT    = 2,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    inout  wire  [DATA_W-1:0]          mcu_fpga_io,
    inout  wire  [N_BANKS*DATA_W-1:0]  fpga_mem_io,
    input  logic                       write_en,
    input  logic                       output_en,
    input  logic [1:0]                 chip_sel,
    input  logic [2:0]                 ecc_sel,
    output logic [2:0]                 flag_out,
    output logic                       busy,
    output logic [CNT_W-1:0]           corr_cnt,
    output logic [CNT_W-1:0]           uncorr_cnt
);

    localparam int CHK_W   = ecc_parity_bits(DATA_W) + 1;
    localparam int CYC_MAX = (WR_CYCLES > RD_LAT) ? WR_CYCLES : RD_LAT;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    bridge_state_e     state, state_nxt;
    logic [CYC_W-1:0]  cyc_cnt, cyc_cnt_nxt;
    logic              capture, sample, finish_rd;

    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_q [N_BANKS];
    logic [CHK_W-1:0]  chk_q [N_BANKS];
    logic [2:0]        flag_q;
    logic              rd_valid_q;
    logic [CNT_W-1:0]  corr_q, uncorr_q;

    logic [DATA_W-1:0] enc_word    [N_BANKS];
    logic [CHK_W-1:0]  enc_chk     [N_BANKS];
    logic [DATA_W-1:0] dec_data    [N_BANKS];
    logic [1:0]        bank_status [N_BANKS];

    logic              selected, wr_req, rd_req;
    logic [DATA_W-1:0] sel_data;
    logic [2:0]        flag_nxt;
    logic              found;
    bank_match_e       match;

    assign selected = ~&chip_sel;
    assign wr_req   = selected & ~write_en;
    assign rd_req   = selected & ~output_en & write_en;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        ecc_bank_codec #(.DATA_W(DATA_W)) u_codec (
            .wr_data  (wr_data_q),
            .mode     (ecc_sel),
            .rd_word  (mem_q[b]),
            .rd_chk   (chk_q[b]),
            .enc_word (enc_word[b]),
            .enc_chk  (enc_chk[b]),
            .dec_data (dec_data[b]),
            .status   (bank_status[b])
        );
        assign fpga_mem_io[b*DATA_W +: DATA_W] =
            (state == ST_WRITE) ? enc_word[b] : {DATA_W{1'bz}};
    end

    // Drive toward the MCU only from IDLE, so it can never overlap the WRITE memory drive.
    assign mcu_fpga_io = (state == ST_IDLE && rd_req && rd_valid_q) ?
                         rd_data_q : {DATA_W{1'bz}};

    always_comb begin
        state_nxt   = state;
        cyc_cnt_nxt = cyc_cnt;
        capture     = 1'b0;
        sample      = 1'b0;
        finish_rd   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wr_req) begin
                    state_nxt   = ST_WRITE;
                    cyc_cnt_nxt = '0;
                    capture     = 1'b1;
                end else if (rd_req) begin
                    state_nxt   = ST_READ_WAIT;
                    cyc_cnt_nxt = '0;
                end
            end
            ST_WRITE: begin
                if (cyc_cnt == CYC_W'(WR_CYCLES - 1)) state_nxt = ST_IDLE;
                else                                  cyc_cnt_nxt = cyc_cnt + 1'b1;
            end
            ST_READ_WAIT: begin
                if (cyc_cnt == CYC_W'(RD_LAT - 1)) begin
                    state_nxt = ST_READ_DONE;
                    sample    = 1'b1;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + 1'b1;
                end
            end
            ST_READ_DONE: begin
                state_nxt = ST_IDLE;
                finish_rd = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Lowest-index recoverable bank wins; with none recoverable, bank 0 is returned raw.
    always_comb begin
        sel_data = dec_data[0];
        found    = 1'b0;
        flag_nxt = '0;
        match    = BANKS_AGREE;
        for (int b = 0; b < N_BANKS; b++) begin
            flag_nxt[FLAG_CORR]   = flag_nxt[FLAG_CORR]   | bank_status[b][STAT_CORR];
            flag_nxt[FLAG_UNCORR] = flag_nxt[FLAG_UNCORR] | bank_status[b][STAT_UNCORR];
            if (!found && !bank_status[b][STAT_UNCORR]) begin
                sel_data = dec_data[b];
                found    = 1'b1;
            end
            if (dec_data[b] != dec_data[0]) match = BANKS_DIFFER;
        end
        flag_nxt[FLAG_MISMATCH] = match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cyc_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            flag_q     <= '0;
            rd_valid_q <= 1'b0;
            corr_q     <= '0;
            uncorr_q   <= '0;
            for (int b = 0; b < N_BANKS; b++) begin
                mem_q[b] <= '0;
                chk_q[b] <= '0;
            end
        end else begin
            if (capture) begin
                wr_data_q  <= mcu_fpga_io;
                flag_q     <= '0;
                rd_valid_q <= 1'b0;
            end
            for (int b = 0; b < N_BANKS; b++) begin
                if (state == ST_WRITE) chk_q[b] <= enc_chk[b];
                if (sample)            mem_q[b] <= fpga_mem_io[b*DATA_W +: DATA_W];
            end
            if (finish_rd) begin
                rd_data_q  <= sel_data;
                flag_q     <= flag_nxt;
                rd_valid_q <= 1'b1;
                if (flag_nxt[FLAG_CORR] && corr_q != '1)     corr_q   <= corr_q + 1'b1;
                if (flag_nxt[FLAG_UNCORR] && uncorr_q != '1) uncorr_q <= uncorr_q + 1'b1;
            end
        end
    end

    assign flag_out   = flag_q;
    assign busy       = (state != ST_IDLE);
    assign corr_cnt   = corr_q;
    assign uncorr_cnt = uncorr_q;

endmodule

// File: tb/tb_ecc_mem_bridge.sv
// Self-checking bench for ecc_mem_bridge: a behavioural two-bank memory with error
// injection, and a scoreboard of expected read results popped when the MCU bus is driven.
module tb_ecc_mem_bridge;

    localparam int DATA_W    = 16;
    localparam int N_BANKS   = 2;
    localparam int WR_CYCLES = 2;
    localparam int RD_LAT    = 2;
    localparam int CNT_W     = 8;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;
    localparam logic [DATA_W-1:0] FLOAT = '1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [2:0]        flag;
        logic [CNT_W-1:0]  corr;
        logic [CNT_W-1:0]  uncorr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              write_en = 1'b1;
    logic              output_en = 1'b1;
    logic [1:0]        chip_sel = 2'b11;
    logic [2:0]        ecc_sel = 3'b000;
    logic [2:0]        flag_out;
    logic              busy;
    logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;

    tri1 [DATA_W-1:0]         mcu_bus;
    tri1 [N_BANKS*DATA_W-1:0] mem_bus;

    logic              mcu_drive = 1'b0;
    logic [DATA_W-1:0] mcu_wdata = '0;
    logic              mem_drive = 1'b0;
    logic [DATA_W-1:0] mem_model [N_BANKS];
    logic [DATA_W-1:0] inj       [N_BANKS];

    exp_t              sb[$];
    int                exp_corr = 0, exp_uncorr = 0;
    logic              model_valid = 1'b0;
    logic [DATA_W-1:0] model_rdata = '0;
    int                checksTotal = 0, checksPassed = 0;

    assign mcu_bus = mcu_drive ? mcu_wdata : {DATA_W{1'bz}};
    for (genvar b = 0; b < N_BANKS; b++) begin : g_mem
        assign mem_bus[b*DATA_W +: DATA_W] = mem_drive ? (mem_model[b] ^ inj[b]) : {DATA_W{1'bz}};
    end

    ecc_mem_bridge #(
        .DATA_W(DATA_W), .N_BANKS(N_BANKS), .WR_CYCLES(WR_CYCLES),
        .RD_LAT(RD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mcu_fpga_io (mcu_bus),
        .fpga_mem_io (mem_bus),
        .write_en    (write_en),
        .output_en   (output_en),
        .chip_sel    (chip_sel),
        .ecc_sel     (ecc_sel),
        .flag_out    (flag_out),
        .busy        (busy),
        .corr_cnt    (corr_cnt),
        .uncorr_cnt  (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic waitDriven(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (mcu_bus === FLOAT && lat < 20);
    endtask

    // Drives one write and records what the bridge puts on each bank into the memory model.
    task automatic writeWord(input logic [DATA_W-1:0] data, input logic [1:0] sel,
                             input bit deselectMid, input bit withRead);
        int busyCycles = 0;
        int driveCycles = 0;
        @(negedge clk);
        mcu_wdata = data; mcu_drive = 1'b1; chip_sel = sel; write_en = 1'b0;
        if (withRead) output_en = 1'b0;
        @(negedge clk);
        write_en = 1'b1; output_en = 1'b1; mcu_drive = 1'b0;
        if (deselectMid) chip_sel = 2'b11;
        checkOutput("wr_flag_cleared", flag_out, 3'b000);
        for (int c = 0; c < WR_CYCLES + 2; c++) begin
            if (busy) busyCycles++;
            if (mem_bus[DATA_W-1:0] !== FLOAT) begin
                driveCycles++;
                for (int b = 0; b < N_BANKS; b++) mem_model[b] = mem_bus[b*DATA_W +: DATA_W];
            end
            @(negedge clk);
        end
        chip_sel = 2'b11;
        checkOutput("wr_busy_cycles", busyCycles, WR_CYCLES);
        checkOutput("wr_drive_cycles", driveCycles, WR_CYCLES);
        for (int b = 0; b < N_BANKS; b++) checkOutput($sformatf("wr_bank%0d", b), mem_model[b], data);
        checkOutput("wr_corr_cnt", corr_cnt, exp_corr);
        checkOutput("wr_uncorr_cnt", uncorr_cnt, exp_uncorr);
        model_valid = 1'b0;
    endtask

    // One read with per-bank injected bit flips; the expectation is queued before the strobe.
    task automatic readWord(input logic [DATA_W-1:0] m0, input logic [DATA_W-1:0] m1,
                            input logic [DATA_W-1:0] expData, input logic [2:0] expFlag);
        exp_t e;
        int lat;
        logic [DATA_W-1:0] got;
        @(negedge clk);
        inj[0] = m0; inj[1] = m1; mem_drive = 1'b1; chip_sel = 2'b01; output_en = 1'b0;
        if (expFlag[0] && exp_corr < CNT_MAX) exp_corr++;
        if (expFlag[1] && exp_uncorr < CNT_MAX) exp_uncorr++;
        e.data = expData; e.flag = expFlag;
        e.corr = CNT_W'(exp_corr); e.uncorr = CNT_W'(exp_uncorr);
        sb.push_back(e);
        #1 checkOutput("rd_early_drive", mcu_bus, model_valid ? model_rdata : FLOAT);
        waitDriven(lat);
        got = mcu_bus;
        e = sb.pop_front();
        checkOutput("rd_latency", lat, RD_LAT + 2);
        checkOutput("rd_data", got, e.data);
        checkOutput("rd_flag", flag_out, e.flag);
        checkOutput("rd_corr_cnt", corr_cnt, e.corr);
        checkOutput("rd_uncorr_cnt", uncorr_cnt, e.uncorr);
        output_en = 1'b1; mem_drive = 1'b0; chip_sel = 2'b11;
        inj[0] = '0; inj[1] = '0;
        model_valid = 1'b1; model_rdata = e.data;
    endtask

    task automatic applyStimulus();
        exp_t e;
        int lat;
        for (int b = 0; b < N_BANKS; b++) begin mem_model[b] = '0; inj[b] = '0; end
        repeat (2) @(negedge clk);
        checkOutput("rst_flag", flag_out, 3'b000);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_corr", corr_cnt, 0);
        checkOutput("rst_uncorr", uncorr_cnt, 0);
        checkOutput("rst_mcu_float", mcu_bus, FLOAT);
        checkOutput("rst_mem_float", mem_bus, {N_BANKS{FLOAT}});
        rst_n = 1'b1;

        writeWord(16'hA5A5, 2'b10, 1'b0, 1'b0);
        readWord(16'h0000, 16'h0000, 16'hA5A5, 3'b000);
        readWord(16'h0008, 16'h0000, 16'hA5A5, 3'b001);
        readWord(16'h0081, 16'h0000, 16'hA5A5, 3'b110);
        readWord(16'h0300, 16'h0300, 16'hA5A5 ^ 16'h0300, 3'b010);
        readWord(16'h0001, 16'h8000, 16'hA5A5, 3'b001);
        readWord(16'h0C00, 16'h0010, 16'hA5A5, 3'b111);
        ecc_sel = 3'b111;
        readWord(16'h0004, 16'h0000, 16'hA5A5 ^ 16'h0004, 3'b100);
        ecc_sel = 3'b000;

        writeWord(16'h3C5A, 2'b00, 1'b1, 1'b0);
        readWord(16'h0000, 16'h0000, 16'h3C5A, 3'b000);

        // Hold output_en low across the return to IDLE: a second read follows at once.
        @(negedge clk);
        mem_drive = 1'b1; chip_sel = 2'b01; output_en = 1'b0;
        e.data = 16'h3C5A; e.flag = 3'b000; e.corr = CNT_W'(exp_corr); e.uncorr = CNT_W'(exp_uncorr);
        sb.push_back(e);
        sb.push_back(e);
        waitDriven(lat);
        e = sb.pop_front();
        checkOutput("hold_first_data", mcu_bus, e.data);
        @(negedge clk);
        checkOutput("hold_restart_busy", busy, 1'b1);
        waitDriven(lat);
        e = sb.pop_front();
        checkOutput("hold_gap", lat, RD_LAT + 1);
        checkOutput("hold_second_data", mcu_bus, e.data);
        output_en = 1'b1; mem_drive = 1'b0; chip_sel = 2'b11;
        model_rdata = e.data;

        writeWord(16'h1234, 2'b01, 1'b0, 1'b1);
        readWord(16'h0000, 16'h0000, 16'h1234, 3'b000);
        for (int n = 0; n < 300; n++)
            readWord(16'(1) << $urandom_range(0, DATA_W - 1), 16'h0000, 16'h1234, 3'b001);
        checkOutput("corr_saturated", corr_cnt, 8'hFF);

        // Reset pulse during the first WRITE cycle.
        @(negedge clk);
        mcu_wdata = 16'h0F0F; mcu_drive = 1'b1; chip_sel = 2'b10; write_en = 1'b0;
        @(negedge clk);
        write_en = 1'b1; mcu_drive = 1'b0; chip_sel = 2'b11;
        checkOutput("wr1_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_mem_float", mem_bus, {N_BANKS{FLOAT}});
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_flag", flag_out, 3'b000);
        checkOutput("arst_corr", corr_cnt, 0);
        checkOutput("arst_uncorr", uncorr_cnt, 0);
        exp_corr = 0; exp_uncorr = 0; model_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int b = 0; b < N_BANKS; b++) mem_model[b] = '0;
        readWord(16'h0000, 16'h0000, 16'h0000, 3'b000);
    endtask

    initial begin
        applyStimulus();
        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
